lifo_stack: RTL
===============

Name: lifo_stack

Overview:
- Parametrised LIFO stack, the successor to the 8-bit, 2**depth-entry push/pop stack used by the accumulator processor controller.
- Adds separate push/pop strobes, a same-cycle push+pop (replace-top) operation, and count/full/empty outputs.
- Adds sticky overflow/underflow error flags and a one-cycle pop-valid strobe.
- Sits between the controller and datapath for call/return addresses and operand spills.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 8, number of entries; any integer >= 2, not required to be a power of two.
- CNT_W, $clog2(DEPTH+1), width of count; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous active-high reset.
- en  input  1  block enable; when 0, push/pop/err_clr are ignored and all state holds.
- push  input  1  push request, sampled at posedge.
- pop  input  1  pop request, sampled at posedge.
- data_in  input  WIDTH  value to push.
- data_out  output  WIDTH  registered; last popped value.
- pop_valid  output  1  registered; 1 for exactly one cycle after an accepted pop.
- count  output  CNT_W  registered number of valid entries.
- full  output  1  count == DEPTH; combinational from the count register.
- empty  output  1  count == 0; combinational from the count register.
- overflow  output  1  sticky; set when a push is rejected.
- underflow  output  1  sticky; set when a pop is rejected.
- err_clr  input  1  clears overflow and underflow (when en=1).

Behaviour:
- Reset (clr=1 at posedge, has priority over everything): count=0, data_out=0, pop_valid=0, overflow=0, underflow=0. Storage array need not be cleared. Reset mid-operation discards all contents; the request in that cycle is dropped.
- Operations when en=1, with top = mem[count-1]:
  - push only, not full: mem[count] <= data_in; count+1; pop_valid=0.
  - push only, full: no write; count unchanged; overflow <= 1.
  - pop only, not empty: data_out <= top; count-1; pop_valid <= 1.
  - pop only, empty: data_out holds; count unchanged; pop_valid <= 0; underflow <= 1.
  - push+pop, not empty (including full): data_out <= old top; mem[count-1] <= data_in; count unchanged; pop_valid <= 1. No overflow is raised, even when full.
  - push+pop, empty: push performed (mem[0] <= data_in, count=1); pop rejected; underflow <= 1; pop_valid <= 0.
  - neither: pop_valid <= 0; all else holds.
- en=0: pop_valid <= 0; count, data_out, memory and flags hold.
- Error flags:
  - err_clr=1 clears both flags in that cycle.
  - If a new error occurs in the same cycle as err_clr, the new error wins and its flag is set.
- Latency: data_out and pop_valid are valid in the cycle after the posedge that accepted the pop.
- Timing of full/empty/count: these reflect the state after the previous edge. A push accepted at edge N makes empty=0 immediately after edge N.
- No wrap-around: count saturates at the bounds via rejection; it never wraps from DEPTH to 0 or from 0 to DEPTH.
- Single always block for sequential state; full/empty are continuous assigns.

Optional Feature:
- Macro: LIFO_STACK_PEEK_EN.
- With the macro defined:
  - Adds input peek_idx [CNT_W-1:0] and output peek_data [WIDTH-1:0].
  - peek_data = mem[count-1-peek_idx], combinational; peek_idx=0 returns the top of stack.
  - peek_data = 0 when peek_idx >= count.
  - Peeking never alters state.
- Without the macro: neither port exists, and behaviour is otherwise identical.

Test Plan:
- Fill/drain:
  - clr, then push 0x11..0x18 (DEPTH=8) -> count=8, full=1, no overflow.
  - Then 8 pops -> data_out 0x18..0x11, one value per pop_valid pulse; finally empty=1.
- Overflow: when full, push 0xAA -> count stays 8, overflow=1; a following pop returns 0x18, not 0xAA.
- Underflow and clear:
  - Pop when empty -> underflow=1, pop_valid=0, data_out holds its prior value.
  - err_clr -> underflow=0.
  - err_clr together with another empty pop -> underflow stays 1.
- Replace-top:
  - With stack 0x01,0x02 (top 0x02), push+pop 0x55 -> data_out=0x02, pop_valid=1, count=2; a next pop gives 0x55.
  - Repeat when full -> no overflow.
- Push+pop on empty with data_in 0x33 -> count=1, underflow=1; a next pop returns 0x33.
- Enable/reset:
  - en=0 with push=1 for 3 cycles -> count unchanged.
  - clr asserted mid-push with count=5 -> next cycle count=0, empty=1, flags=0, data_out=0.

Source files
------------

// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - parametrised LIFO stack with replace-top, count/full/empty and sticky error flags.
// Optional peek port enabled by defining LIFO_STACK_PEEK_EN.
module lifo_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         en,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             data_in,
    output logic [WIDTH-1:0]             data_out,
    output logic                         pop_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic                         underflow,
`ifdef LIFO_STACK_PEEK_EN
    input  logic [$clog2(DEPTH+1)-1:0]   peek_idx,
    output logic [WIDTH-1:0]             peek_data,
`endif
    input  logic                         err_clr
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] top_pos;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    free_idx;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign top_pos  = count - CNT_W'(1);
    assign top_idx  = top_pos[AW-1:0];
    assign free_idx = count[AW-1:0];

    always_ff @(posedge clk) begin
        if (clr) begin
            count     <= '0;
            data_out  <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (en) begin
            pop_valid <= 1'b0;
            // Clear first so that an error raised below in the same cycle wins.
            if (err_clr) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            case ({push, pop})
                2'b10: begin
                    if (!full) begin
                        mem[free_idx] <= data_in;
                        count         <= count + CNT_W'(1);
                    end else begin
                        overflow <= 1'b1;
                    end
                end
                2'b01: begin
                    if (!empty) begin
                        data_out  <= mem[top_idx];
                        count     <= count - CNT_W'(1);
                        pop_valid <= 1'b1;
                    end else begin
                        underflow <= 1'b1;
                    end
                end
                2'b11: begin
                    if (!empty) begin
                        data_out     <= mem[top_idx];
                        mem[top_idx] <= data_in;
                        pop_valid    <= 1'b1;
                    end else begin
                        mem[0]    <= data_in;
                        count     <= CNT_W'(1);
                        underflow <= 1'b1;
                    end
                end
                default: ;
            endcase
        end else begin
            pop_valid <= 1'b0;
        end
    end

`ifdef LIFO_STACK_PEEK_EN
    logic [CNT_W-1:0] peek_pos;
    logic [AW-1:0]    peek_sel;

    assign peek_pos = count - CNT_W'(1) - peek_idx;
    assign peek_sel = peek_pos[AW-1:0];

    always_comb begin
        peek_data = '0;
        if (peek_idx < count)
            peek_data = mem[peek_sel];
    end
`endif

endmodule
